zet_intc: RTL and testbench

Interrupt controller answering the Zet core's maskable-interrupt acknowledge. It latches eight edge-triggered IRQ lines and drives `intr` to the core's decoder. On the one-cycle `inta` pulse it resolves the highest-priority request under fully-nested rules and presents an 8-bit vector for the core's interrupt microcode. Mask, vector base, EOI and status are reached through a small Wishbone slave.

---
 rtl/zet_intc.sv | 116 +++++++++++
 tb/tb_zet_intc.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zet_intc.sv
// Edge-triggered 8-line interrupt controller for the Zet core: fully-nested
// priority, inta-time vector generation, Wishbone access to mask/base/EOI/status.
module zet_intc (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irq,
  output logic       intr,
  input  logic       inta,
  output logic [7:0] vector,
  input  logic [1:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  input  logic       wb_we_i,
  input  logic       wb_stb_i,
  input  logic       wb_cyc_i,
  output logic       wb_ack_o
);

  logic [7:0] r_s1, r_s2, r_h;
  logic [7:0] r_irr, r_isr, r_imr;
  logic [4:0] r_base;
  logic       r_intr;
  logic [7:0] r_vector;
  logic       r_ack;
  logic [7:0] r_dat_o;

  logic [7:0] w_edge;
  logic       w_req, w_wr, w_eoi, w_imr_wr, w_base_wr;
  logic [7:0] w_cand, w_cand_next;
  logic       w_hit;
  logic [2:0] w_k;
  logic [7:0] w_k_onehot;
  logic [7:0] w_irr_next, w_isr_next, w_imr_next;
  logic [7:0] w_rd_data;

  function automatic logic [2:0] f_lowest(input logic [7:0] v);
    f_lowest = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (v[i]) f_lowest = 3'(i);
  endfunction

  // Bits strictly above (higher priority than) the lowest set ISR bit;
  // isolating that bit and subtracting one wraps to all-ones when ISR is empty.
  function automatic logic [7:0] f_above(input logic [7:0] isr);
    f_above = (isr & (~isr + 8'd1)) - 8'd1;
  endfunction

  assign w_edge    = r_s2 & ~r_h;
  assign w_req     = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr      = w_req & wb_we_i;
  assign w_eoi     = w_wr & (wb_adr_i == 2'd0) & wb_dat_i[5];
  assign w_imr_wr  = w_wr & (wb_adr_i == 2'd1);
  assign w_base_wr = w_wr & (wb_adr_i == 2'd2);

  assign w_cand     = r_irr & ~r_imr & f_above(r_isr);
  assign w_hit      = inta & (|w_cand);
  assign w_k        = f_lowest(w_cand);
  assign w_k_onehot = w_hit ? (8'd1 << w_k) : 8'd0;

  // New edges win over the acknowledge clear; EOI acts on the old ISR before the new set.
  assign w_irr_next  = (r_irr & ~w_k_onehot) | w_edge;
  assign w_isr_next  = (w_eoi ? (r_isr & (r_isr - 8'd1)) : r_isr) | w_k_onehot;
  assign w_imr_next  = w_imr_wr ? wb_dat_i : r_imr;
  assign w_cand_next = w_irr_next & ~w_imr_next & f_above(w_isr_next);

  // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    w_rd_data = 8'h00;
    case (wb_adr_i)
      2'd0: w_rd_data = r_irr;
      2'd1: w_rd_data = r_imr;
      2'd2: w_rd_data = {r_base, 3'b000};
      2'd3: w_rd_data = r_isr;
      default: w_rd_data = 8'h00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1     <= 8'h00;
      r_s2     <= 8'h00;
      r_h      <= 8'h00;
      r_irr    <= 8'h00;
      r_isr    <= 8'h00;
      r_imr    <= 8'hFF;
      r_base   <= 5'b00001;
      r_intr   <= 1'b0;
      r_vector <= 8'h08;
      r_ack    <= 1'b0;
      r_dat_o  <= 8'h00;
    end else begin
      r_s1   <= irq;
      r_s2   <= r_s1;
      r_h    <= r_s2;
      r_irr  <= w_irr_next;
      r_isr  <= w_isr_next;
      r_imr  <= w_imr_next;
      r_intr <= |w_cand_next;
      r_ack  <= w_req;
      if (w_req)
        r_dat_o <= w_rd_data;
      if (w_base_wr)
        r_base <= wb_dat_i[7:3];
      // Acknowledge uses the old BASE and IMR; an empty candidate set is spurious.
      if (inta)
        r_vector <= w_hit ? {r_base, w_k} : {r_base, 3'd7};
    end
  end

  assign intr     = r_intr;
  assign vector   = r_vector;
  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat_o;

endmodule

// File: tb/tb_zet_intc.sv
// Directed bench for zet_intc: table of single-acknowledge vectors plus
// hand-written sequences for EOI, nesting, masking, collisions and reset.
module tb_zet_intc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] irq = 8'h00;
  logic       intr;
  logic       inta = 1'b0;
  logic [7:0] vector;
  logic [1:0] wb_adr_i = 2'd0;
  logic [7:0] wb_dat_i = 8'h00;
  logic [7:0] wb_dat_o;
  logic       wb_we_i = 1'b0;
  logic       wb_stb_i = 1'b0;
  logic       wb_cyc_i = 1'b0;
  logic       wb_ack_o;

  int n_tests = 0;
  int n_fail  = 0;

  zet_intc dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq      (irq),
    .intr     (intr),
    .inta     (inta),
    .vector   (vector),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_we_i  (wb_we_i),
    .wb_stb_i (wb_stb_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_ack_o (wb_ack_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] base;
    logic [7:0] imr;
    logic [7:0] irq;
    logic [7:0] vec;
    logic [7:0] isr;
    logic [7:0] irr;
  } vec_t;

  vec_t tbl[8];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [1:0] adr, input logic [7:0] dat,
                         output logic [7:0] rd);
    int n;
    n = 0;
    rd = 8'hxx;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    do begin
      cyc();
      n++;
    end while (!wb_ack_o && n < 8);
    if (!wb_ack_o) begin
      n_tests++;
      n_fail++;
      $display("FAIL wb_ack timeout: got 0 expected 1 (adr %0d)", adr);
    end else begin
      rd = wb_dat_o;
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic wb_write(input logic [1:0] adr, input logic [7:0] dat);
    logic [7:0] dummy;
    wb_xfer(1'b1, adr, dat, dummy);
  endtask

  task automatic wb_check(input string name, input logic [1:0] adr, input logic [7:0] exp);
    logic [7:0] rd;
    wb_xfer(1'b0, adr, 8'h00, rd);
    check(name, rd, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    irq = 8'h00;
    inta = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic inta_pulse();
    inta = 1'b1;
    cyc();
    inta = 1'b0;
  endtask

  // Raise a pattern on irq long enough to be latched, then drop it.
  task automatic irq_pulse(input logic [7:0] pat);
    irq = pat;
    repeat (5) cyc();
    irq = 8'h00;
  endtask

  // Simultaneous inta and Wishbone write in one cycle; ack must be idle first.
  task automatic inta_with_write(input logic [1:0] adr, input logic [7:0] dat);
    cyc();
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = 1'b1;
    wb_adr_i = adr;
    wb_dat_i = dat;
    inta = 1'b1;
    cyc();
    inta = 1'b0;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    check("combined ack", {7'd0, wb_ack_o}, 8'h01);
  endtask

  initial begin
    //            base   imr    irq    vector isr    irr
    tbl[0] = '{8'h20, 8'hFE, 8'h01, 8'h20, 8'h01, 8'h00};
    tbl[1] = '{8'h48, 8'h00, 8'h24, 8'h4A, 8'h04, 8'h20};
    tbl[2] = '{8'h20, 8'h00, 8'h81, 8'h20, 8'h01, 8'h80};
    tbl[3] = '{8'hF8, 8'h0F, 8'hF0, 8'hFC, 8'h10, 8'hE0};
    tbl[4] = '{8'h20, 8'h00, 8'h00, 8'h27, 8'h00, 8'h00};
    tbl[5] = '{8'h20, 8'hFF, 8'h08, 8'h27, 8'h00, 8'h08};
    tbl[6] = '{8'h08, 8'h00, 8'h80, 8'h0F, 8'h80, 8'h00};
    tbl[7] = '{8'h30, 8'h00, 8'h06, 8'h31, 8'h02, 8'h04};

    // Reset values straight out of reset.
    repeat (2) cyc();
    check("reset intr", {7'd0, intr}, 8'h00);
    check("reset vector", vector, 8'h08);
    check("reset ack", {7'd0, wb_ack_o}, 8'h00);
    check("reset dat_o", wb_dat_o, 8'h00);
    rst_n = 1'b1;
    cyc();
    wb_check("reset imr", 2'd1, 8'hFF);
    wb_check("reset base", 2'd2, 8'h08);

    // Table: one acknowledge per record after reset.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      wb_write(2'd2, tbl[i].base);
      wb_write(2'd1, tbl[i].imr);
      irq_pulse(tbl[i].irq);
      check($sformatf("t%0d intr before", i), {7'd0, intr},
            {7'd0, |(tbl[i].irq & ~tbl[i].imr)});
      inta_pulse();
      check($sformatf("t%0d vector", i), vector, tbl[i].vec);
      check($sformatf("t%0d intr after", i), {7'd0, intr}, 8'h00);
      wb_check($sformatf("t%0d isr", i), 2'd3, tbl[i].isr);
      wb_check($sformatf("t%0d irr", i), 2'd0, tbl[i].irr);
    end

    // Single IRQ: bounded latency, base low bits dropped, EOI clears ISR.
    begin
      int n;
      do_reset();
      wb_write(2'd1, 8'hFE);
      wb_write(2'd2, 8'h27);
      wb_check("base readback", 2'd2, 8'h20);
      irq = 8'h01;
      n = 0;
      while (!intr && n < 10) begin
        cyc();
        n++;
      end
      check("single intr rise", {7'd0, intr}, 8'h01);
      irq = 8'h00;
      inta_pulse();
      check("single vector", vector, 8'h20);
      check("single intr drop", {7'd0, intr}, 8'h00);
      wb_check("single isr", 2'd3, 8'h01);
      wb_write(2'd0, 8'h20);
      wb_check("single isr eoi", 2'd3, 8'h00);
    end

    // Priority: 2 before 5, 5 unblocked by EOI.
    do_reset();
    wb_write(2'd2, 8'h20);
    wb_write(2'd1, 8'h00);
    irq_pulse(8'h24);
    inta_pulse();
    check("prio first vector", vector, 8'h22);
    check("prio intr blocked", {7'd0, intr}, 8'h00);
    wb_write(2'd0, 8'h20);
    cyc();
    check("prio intr after eoi", {7'd0, intr}, 8'h01);
    inta_pulse();
    check("prio second vector", vector, 8'h25);
    wb_check("prio isr", 2'd3, 8'h20);

    // Nesting: IRQ3 in service blocks 6, admits 1.
    do_reset();
    wb_write(2'd2, 8'h20);
    wb_write(2'd1, 8'h00);
    irq_pulse(8'h08);
    inta_pulse();
    wb_check("nest isr3", 2'd3, 8'h08);
    irq_pulse(8'h40);
    check("nest irq6 blocked", {7'd0, intr}, 8'h00);
    irq_pulse(8'h02);
    check("nest irq1 intr", {7'd0, intr}, 8'h01);
    inta_pulse();
    check("nest vector", vector, 8'h21);
    wb_check("nest isr", 2'd3, 8'h0A);

    // Mask write in the inta cycle uses old IMR; later masked inta is spurious.
    do_reset();
    wb_write(2'd2, 8'h20);
    wb_write(2'd1, 8'h00);
    irq_pulse(8'h10);
    check("mask intr pending", {7'd0, intr}, 8'h01);
    inta_with_write(2'd1, 8'h10);
    check("mask same-cycle vector", vector, 8'h24);
    wb_check("mask imr", 2'd1, 8'h10);
    wb_check("mask isr", 2'd3, 8'h10);
    irq_pulse(8'h10);
    check("mask intr masked", {7'd0, intr}, 8'h00);
    inta_pulse();
    check("spurious vector", vector, 8'h27);
    wb_check("spurious isr", 2'd3, 8'h10);
    wb_check("spurious irr", 2'd0, 8'h10);

    // New IRQ0 edge lands in the cycle its acknowledge clears IRR[0].
    do_reset();
    wb_write(2'd2, 8'h20);
    wb_write(2'd1, 8'hFE);
    irq_pulse(8'h01);
    repeat (4) cyc();
    check("collide intr", {7'd0, intr}, 8'h01);
    irq = 8'h01;
    cyc();
    cyc();
    inta_pulse();
    irq = 8'h00;
    check("collide vector", vector, 8'h20);
    wb_check("collide irr", 2'd0, 8'h01);
    wb_check("collide isr", 2'd3, 8'h01);

    // EOI and inta in the same cycle: clear ISR[3], then set ISR[2].
    do_reset();
    wb_write(2'd2, 8'h20);
    wb_write(2'd1, 8'h00);
    irq_pulse(8'h08);
    inta_pulse();
    check("eoi-inta first vector", vector, 8'h23);
    irq_pulse(8'h04);
    check("eoi-inta intr", {7'd0, intr}, 8'h01);
    inta_with_write(2'd0, 8'h20);
    check("eoi-inta vector", vector, 8'h22);
    wb_check("eoi-inta isr", 2'd3, 8'h04);

    // Asynchronous reset with pending and in-service state.
    irq_pulse(8'h41);
    check("pre-reset intr", {7'd0, intr}, 8'h01);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async intr", {7'd0, intr}, 8'h00);
    check("async vector", vector, 8'h08);
    check("async ack", {7'd0, wb_ack_o}, 8'h00);
    check("async dat_o", wb_dat_o, 8'h00);
    repeat (2) cyc();
    #2;
    rst_n = 1'b1;
    cyc();
    wb_check("post-reset imr", 2'd1, 8'hFF);
    wb_check("post-reset isr", 2'd3, 8'h00);
    wb_check("post-reset irr", 2'd0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
